// File: rtl/matrix_mem_ctrl.sv
// matrix_mem_ctrl: multi-slot matrix store with combinational ALU reads, ALU write-back
// and a row-major valid/ready streaming loader.
module matrix_mem_ctrl #(
    parameter int NUM_SLOTS = 3,
    parameter int MAX_DIM   = 5,
    parameter int DW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    rd_slot_i,
    input  logic [2:0]    rd_row_i,
    input  logic [2:0]    rd_col_i,
    output logic [DW-1:0] rd_data_o,
    output logic [2:0]    cur_m_o,
    output logic [2:0]    cur_n_o,
    input  logic [1:0]    wr_slot_i,
    input  logic [2:0]    wr_row_i,
    input  logic [2:0]    wr_col_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          wr_we_i,
    input  logic [2:0]    res_m_i,
    input  logic [2:0]    res_n_i,
    input  logic          dim_we_i,
    input  logic          ld_start_i,
    input  logic [1:0]    ld_slot_i,
    input  logic [2:0]    ld_m_i,
    input  logic [2:0]    ld_n_i,
    input  logic          ld_valid_i,
    input  logic [DW-1:0] ld_data_i,
    output logic          ld_ready_o,
    output logic          ld_busy_o,
    output logic          ld_done_o,
    output logic          ld_error_o
);
    localparam int DEPTH = NUM_SLOTS * MAX_DIM * MAX_DIM;
    localparam int IW = $clog2(DEPTH);
    localparam logic [1:0] NS = 2'(NUM_SLOTS);
    localparam logic [2:0] MD = 3'(MAX_DIM);

    typedef enum logic [1:0] {L_IDLE, L_FILL, L_DONE} st_e;

    st_e           st_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic [2:0]    dm_q [NUM_SLOTS];
    logic [2:0]    dn_q [NUM_SLOTS];
    logic [1:0]    slot_q;
    logic [2:0]    lm_q, ln_q, r_q, c_q;
    logic          err_q;
    logic          rd_ok, wr_ok, start_ok, beat, last_col, last;

    function automatic logic [IW-1:0] idx(input logic [1:0] s, input logic [2:0] r, input logic [2:0] c);
        return IW'(s) * IW'(MAX_DIM * MAX_DIM) + IW'(r) * IW'(MAX_DIM) + IW'(c);
    endfunction

    assign rd_ok     = rd_slot_i < NS && rd_row_i < MD && rd_col_i < MD;
    assign rd_data_o = rd_ok ? mem_q[idx(rd_slot_i, rd_row_i, rd_col_i)] : '0;
    assign cur_m_o   = rd_slot_i < NS ? dm_q[rd_slot_i] : '0;
    assign cur_n_o   = rd_slot_i < NS ? dn_q[rd_slot_i] : '0;
    assign wr_ok     = wr_slot_i < NS && wr_row_i < MD && wr_col_i < MD;
    assign start_ok  = ld_slot_i < NS && ld_m_i != 3'd0 && ld_m_i <= MD && ld_n_i != 3'd0 && ld_n_i <= MD;
    // The ALU owns the storage whenever it writes; the loader simply waits a cycle.
    assign ld_ready_o = st_q == L_FILL && !(wr_we_i || dim_we_i);
    assign beat       = ld_ready_o && ld_valid_i;
    assign last_col   = c_q == ln_q - 3'd1;
    assign last       = last_col && r_q == lm_q - 3'd1;
    assign ld_busy_o  = st_q == L_FILL;
    assign ld_done_o  = st_q == L_DONE;
    assign ld_error_o = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= L_IDLE;
            slot_q <= '0;
            lm_q   <= '0;
            ln_q   <= '0;
            r_q    <= '0;
            c_q    <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                dm_q[i] <= '0;
                dn_q[i] <= '0;
            end
        end else begin
            err_q <= 1'b0;
            case (st_q)
                L_IDLE: if (ld_start_i) begin
                    if (start_ok) begin
                        dm_q[ld_slot_i] <= ld_m_i;
                        dn_q[ld_slot_i] <= ld_n_i;
                        slot_q <= ld_slot_i;
                        lm_q   <= ld_m_i;
                        ln_q   <= ld_n_i;
                        r_q    <= '0;
                        c_q    <= '0;
                        st_q   <= L_FILL;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                L_FILL: if (beat) begin
                    mem_q[idx(slot_q, r_q, c_q)] <= ld_data_i;
                    c_q <= last_col ? 3'd0 : c_q + 3'd1;
                    r_q <= last_col ? r_q + 3'd1 : r_q;
                    if (last) st_q <= L_DONE;
                end
                default: st_q <= L_IDLE;
            endcase
            if (wr_we_i && wr_ok) mem_q[idx(wr_slot_i, wr_row_i, wr_col_i)] <= wr_data_i;
            if (dim_we_i && wr_slot_i < NS) begin
                dm_q[wr_slot_i] <= res_m_i;
                dn_q[wr_slot_i] <= res_n_i;
            end
        end
    end
endmodule

// File: tb/tb_matrix_mem_ctrl.sv
// tb_matrix_mem_ctrl: directed and randomized checks of matrix_mem_ctrl against an
// element-count based reference model of storage, dims and the loader.
module tb_matrix_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  rd_slot, wr_slot, ld_slot;
    logic [2:0]  rd_row, rd_col, wr_row, wr_col, res_m, res_n, ld_m, ld_n;
    logic [15:0] wr_data, ld_data;
    logic        wr_we, dim_we, ld_start, ld_valid;
    logic [15:0] rd_data;
    logic [2:0]  cur_m, cur_n;
    logic        ld_ready, ld_busy, ld_done, ld_error;

    matrix_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .rd_slot_i(rd_slot), .rd_row_i(rd_row), .rd_col_i(rd_col),
        .rd_data_o(rd_data), .cur_m_o(cur_m), .cur_n_o(cur_n),
        .wr_slot_i(wr_slot), .wr_row_i(wr_row), .wr_col_i(wr_col),
        .wr_data_i(wr_data), .wr_we_i(wr_we),
        .res_m_i(res_m), .res_n_i(res_n), .dim_we_i(dim_we),
        .ld_start_i(ld_start), .ld_slot_i(ld_slot), .ld_m_i(ld_m), .ld_n_i(ld_n),
        .ld_valid_i(ld_valid), .ld_data_i(ld_data),
        .ld_ready_o(ld_ready), .ld_busy_o(ld_busy), .ld_done_o(ld_done), .ld_error_o(ld_error)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    // Reference model: loader tracked as a count k of accepted elements, placed at (k/n, k%n).
    logic [15:0] mem [3][5][5];
    int dm [3];
    int dn [3];
    bit mbusy, mdone, merr;
    int ls, lm, ln, k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_we = 0; dim_we = 0; ld_start = 0; ld_valid = 0;
        wr_slot = 0; wr_row = 0; wr_col = 0; wr_data = 0; res_m = 0; res_n = 0;
        ld_slot = 0; ld_m = 0; ld_n = 0; ld_data = 0;
    endtask

    task automatic clear_model();
        for (int s = 0; s < 3; s++) begin
            dm[s] = 0; dn[s] = 0;
            for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) mem[s][r][c] = 16'h0;
        end
        mbusy = 0; mdone = 0; merr = 0; k = 0;
    endtask

    task automatic cyc();
        logic [15:0] erd;
        int em, en;
        bit rdy, nd, ne;
        #1;
        erd = 16'h0; em = 0; en = 0;
        if (rd_slot < 3) begin
            em = dm[rd_slot]; en = dn[rd_slot];
            if (rd_row < 5 && rd_col < 5) erd = mem[rd_slot][rd_row][rd_col];
        end
        rdy = mbusy && !(wr_we || dim_we);
        chk("rd_data", rd_data, erd);
        chk("cur_m", cur_m, em);
        chk("cur_n", cur_n, en);
        chk("ld_ready", ld_ready, rdy);
        chk("ld_busy", ld_busy, mbusy);
        chk("ld_done", ld_done, mdone);
        chk("ld_error", ld_error, merr);
        if (ld_done) done_cnt++;
        nd = 0; ne = 0;
        if (!mbusy && !mdone && ld_start) begin
            if (ld_slot < 3 && ld_m >= 1 && ld_m <= 5 && ld_n >= 1 && ld_n <= 5) begin
                dm[ld_slot] = ld_m; dn[ld_slot] = ld_n;
                ls = ld_slot; lm = ld_m; ln = ld_n; k = 0; mbusy = 1;
            end else ne = 1;
        end else if (rdy && ld_valid) begin
            mem[ls][k / ln][k % ln] = ld_data;
            k++;
            if (k == lm * ln) begin mbusy = 0; nd = 1; end
        end
        if (wr_we && wr_slot < 3 && wr_row < 5 && wr_col < 5) mem[wr_slot][wr_row][wr_col] = wr_data;
        if (dim_we && wr_slot < 3) begin dm[wr_slot] = res_m; dn[wr_slot] = res_n; end
        mdone = nd; merr = ne;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        #1;
        clear_model();
        chk("rst_rd_data", rd_data, 0);
        chk("rst_cur_m", cur_m, 0);
        chk("rst_busy", ld_busy, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_done", ld_done, 0);
        chk("rst_error", ld_error, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic start(input logic [1:0] s, input logic [2:0] m, input logic [2:0] n);
        ld_start = 1; ld_slot = s; ld_m = m; ld_n = n;
        cyc();
        ld_start = 0;
    endtask

    // Feeds sequential data until the model loader finishes; optional ALU stall or reset at a beat.
    task automatic feed(input bit toggle, input int stall_beat, input int rst_beat, input int base);
        int t, v;
        bit stalled;
        t = 0; v = base; stalled = 0;
        while (mbusy && t < 200) begin
            ld_valid = toggle ? (t % 2 == 0) : 1'b1;
            ld_data = 16'(v);
            if (k == rst_beat) begin
                do_reset();
                break;
            end
            if (k == stall_beat && !stalled) begin
                wr_we = 1; wr_slot = 1; wr_row = 2; wr_col = 2; wr_data = 16'h7fff; stalled = 1;
                #1;
                chk("stall_ready", ld_ready, 0);
            end
            if (ld_valid && !wr_we) v++;
            cyc();
            wr_we = 0;
            t++;
        end
        ld_valid = 0;
        chk("load_timeout", t < 200, 1);
        cyc();
    endtask

    task automatic readback(input logic [1:0] s);
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) begin
            rd_slot = s; rd_row = 3'(r); rd_col = 3'(c);
            cyc();
        end
    endtask

    initial begin
        int d0;
        logic [15:0] cvals [6];
        idle();
        rd_slot = 0; rd_row = 0; rd_col = 0;
        do_reset();
        cyc();

        start(2'd0, 3'd2, 3'd3);
        feed(0, -1, -1, 1);
        rd_slot = 0; rd_row = 1; rd_col = 2;
        #1;
        chk("t1_rd12", rd_data, 6);
        chk("t1_dims", {cur_m, cur_n}, {3'd2, 3'd3});
        cyc();

        start(2'd1, 3'd0, 3'd2);
        chk("t2_err_m0", ld_error, 1);
        cyc();
        start(2'd3, 3'd2, 3'd2);
        chk("t2_err_slot3", ld_error, 1);
        cyc();
        start(2'd1, 3'd2, 3'd6);
        chk("t2_err_n6", ld_error, 1);
        chk("t2_busy", ld_busy, 0);
        cyc();
        readback(2'd0);
        readback(2'd1);

        start(2'd2, 3'd2, 3'd2);
        feed(0, 3, -1, 16'h10);
        readback(2'd2);
        rd_slot = 2; rd_row = 1; rd_col = 1;
        #1;
        chk("t3_elem3", rd_data, 16'h13);
        rd_slot = 1; rd_row = 2; rd_col = 2;
        #1;
        chk("t3_alu", rd_data, 16'h7fff);
        cyc();

        cvals = '{16'h0001, 16'hffff, 16'h7fff, 16'h8000, 16'h0005, 16'hfffe};
        dim_we = 1; wr_slot = 2; res_m = 3; res_n = 2;
        cyc();
        dim_we = 0;
        for (int i = 0; i < 6; i++) begin
            wr_we = 1; wr_slot = 2; wr_row = 3'(i / 2); wr_col = 3'(i % 2); wr_data = cvals[i];
            cyc();
        end
        wr_we = 0;
        readback(2'd2);
        rd_slot = 2; rd_row = 2; rd_col = 1;
        #1;
        chk("t4_neg", rd_data, 16'hfffe);
        chk("t4_dims", {cur_m, cur_n}, {3'd3, 3'd2});
        cyc();

        d0 = done_cnt;
        start(2'd1, 3'd5, 3'd5);
        feed(0, -1, 10, 100);
        chk("t5_no_done", done_cnt, d0);
        for (int s = 0; s < 3; s++) readback(2'(s));

        d0 = done_cnt;
        start(2'd1, 3'd5, 3'd5);
        feed(1, -1, -1, 200);
        chk("t6_done_once", done_cnt - d0, 1);
        rd_slot = 1; rd_row = 4; rd_col = 4;
        #1;
        chk("t6_last", rd_data, 224);
        cyc();
        readback(2'd1);

        for (int i = 0; i < 2000; i++) begin
            rd_slot = 2'($urandom_range(0, 3)); rd_row = 3'($urandom_range(0, 7)); rd_col = 3'($urandom_range(0, 7));
            wr_we = ($urandom % 6) == 0;
            wr_slot = 2'($urandom_range(0, 3)); wr_row = 3'($urandom_range(0, 5)); wr_col = 3'($urandom_range(0, 5));
            wr_data = 16'($urandom);
            dim_we = ($urandom % 15) == 0;
            res_m = 3'($urandom_range(0, 7)); res_n = 3'($urandom_range(0, 7));
            ld_start = ($urandom % 10) == 0;
            ld_slot = 2'($urandom_range(0, 3)); ld_m = 3'($urandom_range(0, 6)); ld_n = 3'($urandom_range(0, 6));
            if (ld_start) dim_we = 0;
            ld_valid = ($urandom % 3) != 0;
            ld_data = 16'($urandom);
            cyc();
        end
        idle();
        for (int i = 0; i < 60; i++) cyc();
        for (int s = 0; s < 3; s++) readback(2'(s));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
